sipo_deser: RTL and testbench

Serial-in, parallel-out deserializer: the receive-side counterpart of the team's 4-bit load/shift PISO. It samples one serial bit per enabled clock, MSB first, and assembles WIDTH-bit words. Each completed word moves into an output holding register with a valid/ready handshake. The block sits at the far end of a PISO serial link and hands words to downstream parallel logic.

---
 rtl/sipo_deser_pkg.sv | 12 +
 rtl/sipo_hold.sv | 50 +++++
 rtl/sipo_deser.sv | 77 +++++++
 tb/tb_sipo_deser.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/sipo_deser_pkg.sv
// Shared definitions for the serial link: deserializer FSM encoding and the
// default word width agreed with the PISO at the other end.
package sipo_deser_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/sipo_hold.sv
// Output holding register for completed words: valid/ready handshake with a
// sticky overrun flag raised when a finished word finds the register still full.
module sipo_hold
   import sipo_deser_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] word,
   input  logic             clear,
   input  logic             pout_ready,
   output logic [WIDTH-1:0] pout,
   output logic             pout_valid,
   output logic             overrun
);

   logic accept;
   logic room;

   assign accept = pout_valid && pout_ready;
   // A full register still has room when its word leaves on this same edge.
   assign room   = !pout_valid || pout_ready;

   // NOTE: the data register is reset too, because pout is a visible output
   // with a defined reset value, not just a payload qualified by valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pout       <= '0;
         pout_valid <= 1'b0;
      end else if (load && room) begin
         pout       <= word;
         pout_valid <= 1'b1;
      end else if (accept) begin
         pout_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (clear) begin
         overrun <= 1'b0;
      end else if (load && !room) begin
         overrun <= 1'b1;
      end
   end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer: collects WIDTH bits MSB first and hands
// each finished word to a valid/ready holding register.
module sipo_deser
   import sipo_deser_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sin,
   input  logic                       sin_en,
   input  logic                       clear,
   output logic [WIDTH-1:0]           pout,
   output logic                       pout_valid,
   input  logic                       pout_ready,
   output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
   output logic                       busy,
   output logic                       overrun
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state;
   state_t           state_next;
   // Only the WIDTH-1 earlier bits need storing: the last bit comes straight from sin.
   logic [WIDTH-2:0] shreg;
   logic [WIDTH-1:0] word;
   logic             shift;
   logic             complete;

   assign shift    = sin_en && !clear;
   assign complete = shift && (bit_cnt == CW'(WIDTH - 1));
   assign word     = {shreg, sin};
   assign busy     = (state == SHIFT);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (clear) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (shift) begin
         shreg   <= word[WIDTH-2:0];
         bit_cnt <= complete ? '0 : bit_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_next = state;
      if (clear)       state_next = IDLE;
      else if (sin_en) state_next = complete ? IDLE : SHIFT;
   end

   sipo_hold #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk        (clk),
      .rst        (rst),
      .load       (complete),
      .word       (word),
      .clear      (clear),
      .pout_ready (pout_ready),
      .pout       (pout),
      .pout_valid (pout_valid),
      .overrun    (overrun)
   );

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser (WIDTH=4): direct checks plus a scoreboard
// of expected words popped on every valid/ready handshake.
module tb_sipo_deser;

   localparam int WIDTH = 4;
   localparam int CW    = $clog2(WIDTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             sin;
   logic             sin_en;
   logic             clear;
   logic [WIDTH-1:0] pout;
   logic             pout_valid;
   logic             pout_ready;
   logic [CW-1:0]    bit_cnt;
   logic             busy;
   logic             overrun;

   int               n_tests = 0;
   int               n_fail  = 0;
   logic [WIDTH-1:0] sb[$];

   sipo_deser #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .sin        (sin),
      .sin_en     (sin_en),
      .clear      (clear),
      .pout       (pout),
      .pout_valid (pout_valid),
      .pout_ready (pout_ready),
      .bit_cnt    (bit_cnt),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after each rising edge; direct checks run there too.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      sin    = b;
      sin_en = 1'b1;
      step();
      sin_en = 1'b0;
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w, input bit expect_kept);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (i == 0 && expect_kept) sb.push_back(w);
         send_bit(w[i]);
      end
   endtask

   task automatic accept();
      pout_ready = 1'b1;
      step();
      pout_ready = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_pout"},    32'(pout),       32'h0);
      check({tag, "_valid"},   32'(pout_valid), 32'h0);
      check({tag, "_bit_cnt"}, 32'(bit_cnt),    32'h0);
      check({tag, "_busy"},    32'(busy),       32'h0);
      check({tag, "_overrun"}, 32'(overrun),    32'h0);
   endtask

   // Scoreboard: every accepted word must match the oldest expected one.
   always @(negedge clk) begin
      if (!rst && pout_valid && pout_ready) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_word", 32'(pout), 32'hFFFF_FFFF);
         end else begin
            automatic logic [WIDTH-1:0] exp = sb.pop_front();
            check("sb_word", 32'(pout), 32'(exp));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] gap_word;
      rst        = 1'b1;
      sin        = 1'b0;
      sin_en     = 1'b0;
      clear      = 1'b0;
      pout_ready = 1'b0;
      #12;
      check_reset_values("reset");
      rst = 1'b0;

      // Basic word 1,0,1,1
      send_word(4'hB, 1'b1);
      check("basic_pout",    32'(pout),       32'hB);
      check("basic_valid",   32'(pout_valid), 32'h1);
      check("basic_bit_cnt", 32'(bit_cnt),    32'h0);
      check("basic_busy",    32'(busy),       32'h0);
      accept();
      check("basic_accepted", 32'(pout_valid), 32'h0);
      check("basic_pout_kept", 32'(pout),      32'hB);

      // Gapped input 0,1,1,0
      gap_word = 4'h6;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (i == 0) sb.push_back(gap_word);
         send_bit(gap_word[i]);
         check("gap_bit_cnt", 32'(bit_cnt), 32'((WIDTH - i) % WIDTH));
         check("gap_busy",    32'(busy),    (i == 0) ? 32'h0 : 32'h1);
         repeat ($urandom_range(1, 3)) step();
         check("gap_hold_cnt", 32'(bit_cnt), 32'((WIDTH - i) % WIDTH));
      end
      check("gap_pout",  32'(pout),       32'h6);
      check("gap_valid", 32'(pout_valid), 32'h1);
      accept();

      // Back-to-back: A is held, 5 follows with no gap, ready on 5's last edge
      send_word(4'hA, 1'b1);
      check("b2b_first", 32'(pout), 32'hA);
      for (int i = WIDTH - 1; i >= 1; i--) begin
         send_bit(i[0] ? 1'b0 : 1'b1);
         check("b2b_hold_pout",  32'(pout),       32'hA);
         check("b2b_hold_valid", 32'(pout_valid), 32'h1);
         check("b2b_overrun",    32'(overrun),    32'h0);
      end
      sb.push_back(4'h5);
      pout_ready = 1'b1;
      send_bit(1'b1);
      pout_ready = 1'b0;
      check("b2b_second",  32'(pout),       32'h5);
      check("b2b_valid",   32'(pout_valid), 32'h1);
      check("b2b_overrun", 32'(overrun),    32'h0);
      accept();

      // Overrun: 3 held, C dropped
      send_word(4'h3, 1'b1);
      send_word(4'hC, 1'b0);
      check("ovr_pout",  32'(pout),       32'h3);
      check("ovr_flag",  32'(overrun),    32'h1);
      check("ovr_valid", 32'(pout_valid), 32'h1);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("ovr_cleared", 32'(overrun),    32'h0);
      check("ovr_kept",    32'(pout),       32'h3);
      check("ovr_valid2",  32'(pout_valid), 32'h1);
      accept();

      // Clear mid-word, together with sin_en
      send_bit(1'b1);
      send_bit(1'b0);
      check("clr_pre_cnt",  32'(bit_cnt), 32'h2);
      check("clr_pre_busy", 32'(busy),    32'h1);
      clear  = 1'b1;
      sin    = 1'b1;
      sin_en = 1'b1;
      step();
      clear  = 1'b0;
      sin_en = 1'b0;
      check("clr_cnt",   32'(bit_cnt),    32'h0);
      check("clr_busy",  32'(busy),       32'h0);
      check("clr_valid", 32'(pout_valid), 32'h0);
      send_word(4'hF, 1'b1);
      check("clr_next_pout", 32'(pout), 32'hF);
      accept();

      // Async reset mid-word with a held word
      send_word(4'h9, 1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      check("arst_pre_cnt", 32'(bit_cnt),    32'h3);
      check("arst_pre_vld", 32'(pout_valid), 32'h1);
      #1;
      rst = 1'b1;
      #1;
      check_reset_values("arst");
      sb.delete();
      rst = 1'b0;
      send_word(4'hD, 1'b1);
      check("arst_next_pout",  32'(pout),       32'hD);
      check("arst_next_valid", 32'(pout_valid), 32'h1);
      accept();

      step();
      check("sb_drained", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
